// File: rtl/myproject_mac_sxu_pipe.sv
// Pipelined signed x unsigned multiplier with optional run accumulation.
// Accumulate mode sums tagged runs and emits one saturated result per run.
module myproject_mac_sxu_pipe #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 10,
   parameter int dout_WIDTH = 26,
   parameter int ACC_WIDTH  = 32,
   parameter int ACC_EN     = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  din_vld,
   input  logic                  acc_clr,
   input  logic                  acc_last,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  dout_vld,
   output logic                  sat_flag
);

   localparam int P = din0_WIDTH + din1_WIDTH + 1;
   localparam int N = NUM_STAGE;
   localparam int D = dout_WIDTH;
   localparam int A = ACC_WIDTH;

   logic signed [P-1:0] w_a;
   logic signed [P-1:0] w_b;
   logic signed [P-1:0] w_prod;

   assign w_a    = P'($signed(din0));
   assign w_b    = P'($signed({1'b0, din1}));
   assign w_prod = w_a * w_b;

   logic signed [P-1:0] r_p [N];
   logic                r_v [N];
   logic                r_c [N];
   logic                r_l [N];

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         for (int i = 0; i < N; i++) begin
            r_p[i] <= '0;
            r_v[i] <= 1'b0;
            r_c[i] <= 1'b0;
            r_l[i] <= 1'b0;
         end
      end else if (ce) begin
         r_p[0] <= w_prod;
         r_v[0] <= din_vld;
         r_c[0] <= acc_clr;
         r_l[0] <= acc_last;
         for (int i = 1; i < N; i++) begin
            r_p[i] <= r_p[i-1];
            r_v[i] <= r_v[i-1];
            r_c[i] <= r_c[i-1];
            r_l[i] <= r_l[i-1];
         end
      end
   end

   logic signed [A-1:0] w_pext;
   logic signed [A-1:0] w_acc_nxt;
   logic signed [A-1:0] r_acc;
   logic [D-1:0]        w_sat_val;
   logic                w_clip;
   logic [D-1:0]        w_mul_dout;
   logic [D-1:0]        r_dout;
   logic                r_vld;
   logic                r_sat;

   assign w_pext    = A'(r_p[N-1]);
   assign w_acc_nxt = r_c[N-1] ? w_pext : r_acc + w_pext;

   // Clip when the bits above the output sign bit disagree with it.
   generate
      if (D < A) begin : g_sat
         logic [A-D:0] w_hi;
         assign w_hi   = w_acc_nxt[A-1:D-1];
         assign w_clip = !((&w_hi) || !(|w_hi));
         assign w_sat_val = !w_clip ? w_acc_nxt[D-1:0] :
                            w_acc_nxt[A-1] ? {1'b1, {(D-1){1'b0}}} :
                                             {1'b0, {(D-1){1'b1}}};
      end else begin : g_nosat
         assign w_clip    = 1'b0;
         assign w_sat_val = D'(w_acc_nxt);
      end
   endgenerate

   generate
      if (D <= P) begin : g_trunc
         assign w_mul_dout = r_p[N-1][D-1:0];
      end else begin : g_sext
         assign w_mul_dout = D'(r_p[N-1]);
      end
   endgenerate

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_acc  <= '0;
         r_dout <= '0;
         r_vld  <= 1'b0;
         r_sat  <= 1'b0;
      end else if (ce) begin
         r_vld <= r_v[N-1] && r_l[N-1];
         if (r_v[N-1]) begin
            r_acc <= w_acc_nxt;
         end
         if (r_v[N-1] && r_l[N-1]) begin
            r_dout <= w_sat_val;
            r_sat  <= w_clip;
         end
      end
   end

   assign dout     = (ACC_EN != 0) ? r_dout : w_mul_dout;
   assign dout_vld = (ACC_EN != 0) ? r_vld  : r_v[N-1];
   assign sat_flag = (ACC_EN != 0) ? r_sat  : 1'b0;

endmodule

// File: tb/tb_myproject_mac_sxu_pipe.sv
// Scoreboard bench: three configurations (plain multiply, accumulate,
// accumulate into a 16-bit output) share one randomized stimulus stream.
module tb_myproject_mac_sxu_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b1;
   logic [15:0] din0 = '0;
   logic [9:0]  din1 = '0;
   logic        vld = 1'b0;
   logic        clr = 1'b0;
   logic        last = 1'b0;

   logic [25:0] dout0, dout1;
   logic [15:0] dout2;
   logic        vld0, vld1, vld2;
   logic        sat0, sat1, sat2;

   always #5 clk = ~clk;

   myproject_mac_sxu_pipe #(.NUM_STAGE(3), .dout_WIDTH(26), .ACC_EN(0)) u_mul (
      .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
      .din_vld(vld), .acc_clr(clr), .acc_last(last),
      .dout(dout0), .dout_vld(vld0), .sat_flag(sat0));

   myproject_mac_sxu_pipe #(.NUM_STAGE(3), .dout_WIDTH(26), .ACC_EN(1)) u_acc (
      .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
      .din_vld(vld), .acc_clr(clr), .acc_last(last),
      .dout(dout1), .dout_vld(vld1), .sat_flag(sat1));

   myproject_mac_sxu_pipe #(.NUM_STAGE(2), .dout_WIDTH(16), .ACC_EN(1)) u_sat (
      .ap_clk(clk), .ap_rst(rst), .ce(ce), .din0(din0), .din1(din1),
      .din_vld(vld), .acc_clr(clr), .acc_last(last),
      .dout(dout2), .dout_vld(vld2), .sat_flag(sat2));

   typedef struct {
      longint d;
      bit     s;
      int     due;
   } exp_t;

   exp_t   q[3][$];
   longint acc_m[3];
   int     NS[3] = '{3, 3, 2};
   int     DW[3] = '{26, 26, 16};
   int     AE[3] = '{0, 1, 1};

   int total = 0;
   int bad = 0;
   int n_ce = 0;
   bit last_ce = 1'b0;
   bit rst_edge = 1'b1;
   bit started = 1'b0;
   longint pd[3];
   bit     pv[3];
   bit     ps[3];

   function automatic longint wrapw(longint v, int w);
      longint m;
      m = v & ((longint'(1) << w) - 1);
      if (m >= (longint'(1) << (w - 1))) m -= (longint'(1) << w);
      return m;
   endfunction

   task automatic chk(string nm, int idx, bit ok, longint got, longint exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s[%0d]: got %0d want %0d at t=%0t", nm, idx, got, exp, $time);
      end
   endtask

   // Reference model: runs are plain integer sums clipped to the output range.
   task automatic model(int i, longint p, bit c, bit l);
      exp_t   e;
      longint hi, lo;
      if (AE[i] == 0) begin
         e.d = wrapw(p, DW[i]);
         e.s = 1'b0;
         e.due = n_ce + NS[i] - 1;
         q[i].push_back(e);
      end else begin
         acc_m[i] = wrapw(c ? p : acc_m[i] + p, 32);
         if (l) begin
            hi = (longint'(1) << (DW[i] - 1)) - 1;
            lo = -(longint'(1) << (DW[i] - 1));
            e.s = (acc_m[i] > hi) || (acc_m[i] < lo);
            e.d = (acc_m[i] > hi) ? hi : (acc_m[i] < lo) ? lo : acc_m[i];
            e.due = n_ce + NS[i];
            q[i].push_back(e);
         end
      end
   endtask

   always @(posedge clk) begin
      longint p;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            q[i].delete();
            acc_m[i] = 0;
         end
         last_ce = 1'b0;
         rst_edge = 1'b1;
      end else begin
         rst_edge = 1'b0;
         last_ce = ce;
         if (ce) begin
            n_ce++;
            if (vld) begin
               p = longint'($signed(din0)) * longint'(din1);
               for (int i = 0; i < 3; i++) model(i, p, clr, last);
            end
         end
      end
   end

   always @(negedge clk) begin
      longint gd[3];
      bit     gv[3];
      bit     gs[3];
      exp_t   e;
      gd[0] = longint'($signed(dout0));
      gd[1] = longint'($signed(dout1));
      gd[2] = longint'($signed(dout2));
      gv = '{vld0, vld1, vld2};
      gs = '{sat0, sat1, sat2};
      if (started && !rst_edge) begin
         for (int i = 0; i < 3; i++) begin
            if (last_ce) begin
               if (gv[i]) begin
                  if (q[i].size() == 0) begin
                     chk("unexpected_vld", i, 1'b0, gd[i], 0);
                  end else begin
                     e = q[i].pop_front();
                     chk("dout", i, gd[i] == e.d, gd[i], e.d);
                     chk("sat", i, gs[i] == e.s, longint'(gs[i]), longint'(e.s));
                     chk("latency", i, n_ce == e.due, n_ce, e.due);
                  end
               end
            end else begin
               chk("hold_vld", i, gv[i] == pv[i], longint'(gv[i]), longint'(pv[i]));
               chk("hold_dout", i, gd[i] == pd[i], gd[i], pd[i]);
               chk("hold_sat", i, gs[i] == ps[i], longint'(gs[i]), longint'(ps[i]));
            end
         end
      end
      pd = gd;
      pv = gv;
      ps = gs;
   end

   task automatic drv(bit c, bit v, int d0, int d1, bit cl, bit la);
      @(negedge clk);
      ce = c;
      vld = v;
      din0 = d0[15:0];
      din1 = d1[9:0];
      clr = cl;
      last = la;
   endtask

   task automatic idle(int n);
      repeat (n) drv(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_dout", 0, dout0 == 0, longint'(dout0), 0);
      chk("rst_dout", 1, dout1 == 0, longint'(dout1), 0);
      chk("rst_dout", 2, dout2 == 0, longint'(dout2), 0);
      chk("rst_vld", 0, {vld0, vld1, vld2} == 3'b000, longint'({vld0, vld1, vld2}), 0);
      chk("rst_sat", 0, {sat0, sat1, sat2} == 3'b000, longint'({sat0, sat1, sat2}), 0);
      rst = 1'b0;
      started = 1'b1;

      drv(1, 1, -3, 1023, 1, 1);
      idle(6);
      for (int t = 0; t < 4; t++) drv(1, 1, 100, 10, t == 0, t == 3);
      idle(6);
      for (int t = 0; t < 3; t++) drv(1, 1, 32767, 1023, t == 0, t == 2);
      idle(6);
      for (int t = 0; t < 3; t++) drv(1, 1, -32768, 1023, t == 0, t == 2);
      idle(6);

      drv(1, 1, 100, 10, 1, 0);
      drv(1, 0, 0, 0, 0, 0);
      repeat (5) drv(0, 1, 1234, 77, 1, 1);
      drv(1, 1, 100, 10, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
      drv(1, 1, 100, 10, 0, 0);
      drv(1, 1, 100, 10, 0, 1);
      idle(3);
      repeat (3) drv(0, 0, 0, 0, 0, 0);
      idle(6);

      drv(1, 1, 5, 5, 1, 0);
      drv(1, 1, 6, 6, 0, 1);
      @(negedge clk);
      rst = 1'b1;
      vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      drv(1, 1, 7, 7, 1, 1);
      idle(6);

      for (int t = 0; t < 8; t++)
         drv(1, 1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)), 1, 1);
      idle(6);

      for (int t = 0; t < 400; t++)
         drv($urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7,
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)),
             $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      idle(10);

      for (int i = 0; i < 3; i++)
         chk("drain", i, q[i].size() == 0, longint'(q[i].size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
